// File: rtl/apb_pkg.sv
// Shared widths, state encoding and address-range helper for the APB wait-state completer.
package apb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } cmp_state_e;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr, input int depth);
        return int'(addr) >= depth;
    endfunction

endpackage

// File: rtl/apb_cmp_mem.sv
// DEPTH x 8 register file: synchronous write, asynchronous read, synchronous clear.
module apb_cmp_mem
    import apb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: clearing the whole array on reset keeps it out of a RAM macro;
    // software relies on reading zeros from untouched locations.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && int'(waddr) < DEPTH) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) rdata = mem[raddr];
    end

endmodule

// File: rtl/apb_wait_completer.sv
// APB completer with WAIT_CYCLES programmable wait states and a local register file.
// Define APB_SLVERR_EN to flag out-of-range addresses with PSLVERR; otherwise addresses wrap.
module apb_wait_completer
    import apb_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmp_state_e        state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;

    logic              setup, access;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wr, sel_err, lat_err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr;

    assign setup  = PSEL && !PENABLE;
    assign access = PSEL && PENABLE;

    // Outputs are registered on the edge entering DONE; for a zero-wait transfer
    // that edge is also the setup edge, so decode from the live bus in IDLE.
    assign sel_addr = (state == IDLE) ? PADDR  : addr_q;
    assign sel_wr   = (state == IDLE) ? PWRITE : wr_q;

`ifdef APB_SLVERR_EN
    assign sel_err = out_of_range(sel_addr, DEPTH);
    assign lat_err = out_of_range(addr_q, DEPTH);
`else
    assign sel_err = 1'b0;
    assign lat_err = 1'b0;
`endif

    assign unused_addr = ^{sel_addr, addr_q};
    assign mem_we      = (state == DONE) && access && wr_q && !lat_err;

    apb_cmp_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (mem_we),
        .waddr (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .raddr (sel_addr[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default before the case, so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (setup) next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
            WAIT: begin
                if (!PSEL)                         next_state = IDLE;
                else if (PENABLE && cnt == CNT_W'(1)) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            if (state == IDLE && setup) begin
                addr_q  <= PADDR;
                wdata_q <= PWDATA;
                wr_q    <= PWRITE;
                cnt     <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT && access) begin
                cnt <= cnt - CNT_W'(1);
            end
            PREADY  <= (next_state == DONE);
            PSLVERR <= (next_state == DONE) && sel_err;
            PRDATA  <= ((next_state == DONE) && !sel_wr && !sel_err) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_wait_completer.sv
// Directed bench for apb_wait_completer: one instance with 2 wait states, one with none.
`timescale 1ns/1ps
module tb_apb_wait_completer;

    logic       pclk = 1'b0;
    logic       preset;
    logic       psel2, psel0;
    logic       penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata2, prdata0;
    logic       pready2, pready0, pslverr2, pslverr0;

    bit         use0;
    logic [7:0] obs_rdata;
    logic       obs_ready, obs_err;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_wait_completer #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
        .PCLK    (pclk),
        .PRESET  (preset),
        .PSEL    (psel2),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata2),
        .PREADY  (pready2),
        .PSLVERR (pslverr2)
    );

    apb_wait_completer #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .PCLK    (pclk),
        .PRESET  (preset),
        .PSEL    (psel0),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata0),
        .PREADY  (pready0),
        .PSLVERR (pslverr0)
    );

    assign obs_rdata = use0 ? prdata0  : prdata2;
    assign obs_ready = use0 ? pready0  : pready2;
    assign obs_err   = use0 ? pslverr0 : pslverr2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transfer on the selected instance; bus is scrambled after setup.
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input bit exp_err, input string tag);
        int waits;
        waits = use0 ? 0 : 2;
        @(posedge pclk); #1;
        if (use0) psel0 = 1'b1; else psel2 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        check({tag, "_t0_ready"}, obs_ready, 0);
        @(posedge pclk); #1;
        penable = 1'b1; pwrite = ~wr; paddr = ~a; pwdata = ~d;
        for (int k = 0; k <= waits; k++) begin
            @(negedge pclk);
            check($sformatf("%s_ready_t%0d", tag, k + 1), obs_ready, (k == waits));
            if (k < waits) begin
                @(posedge pclk); #1;
            end
        end
        check({tag, "_slverr"}, obs_err, exp_err);
        if (!wr) check({tag, "_rdata"}, obs_rdata, exp_rd);
    endtask

    task automatic idle(input string tag);
        @(posedge pclk); #1;
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check({tag, "_idle_ready"}, obs_ready, 0);
        check({tag, "_idle_rdata"}, obs_rdata, 0);
    endtask

    initial begin
        preset = 1'b1; psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; use0 = 1'b0;

        // Reset
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_prdata",  prdata2,  8'h00);
        check("rst_pready",  pready2,  0);
        check("rst_pslverr", pslverr2, 0);
        check("rst0_pready", pready0,  0);
        @(posedge pclk); #1;
        preset = 1'b0;
        xfer(1'b0, 8'h05, 8'h00, 8'h00, 1'b0, "rst_rd05");
        idle("rst_rd05");

        // Write then read with two wait states
        xfer(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, "wr10");
        idle("wr10");
        xfer(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, "rd10");
        idle("rd10");

        // Zero-wait back-to-back write/read
        use0 = 1'b1;
        xfer(1'b1, 8'h01, 8'h3C, 8'h00, 1'b0, "b2b_wr");
        xfer(1'b0, 8'h01, 8'h00, 8'h3C, 1'b0, "b2b_rd");
        idle("b2b");
        use0 = 1'b0;

        // Out-of-range address
`ifdef APB_SLVERR_EN
        xfer(1'b1, 8'h50, 8'hFF, 8'h00, 1'b1, "err_wr50");
        idle("err_wr50");
        xfer(1'b0, 8'h50, 8'h00, 8'h00, 1'b1, "err_rd50");
        idle("err_rd50");
        xfer(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, "err_rd10");
        idle("err_rd10");
`else
        xfer(1'b1, 8'h50, 8'hFF, 8'h00, 1'b0, "wrap_wr50");
        idle("wrap_wr50");
        xfer(1'b0, 8'h50, 8'h00, 8'hFF, 1'b0, "wrap_rd50");
        idle("wrap_rd50");
        xfer(1'b0, 8'h10, 8'h00, 8'hFF, 1'b0, "wrap_rd10");
        idle("wrap_rd10");
`endif

        // Abort: PSEL dropped in T1
        xfer(1'b1, 8'h20, 8'h42, 8'h00, 1'b0, "abt_pre");
        idle("abt_pre");
        @(posedge pclk); #1;
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h77;
        @(posedge pclk); #1;
        psel2 = 1'b0; penable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            check($sformatf("abt_ready_c%0d", k), pready2, 0);
        end
        @(posedge pclk); #1;
        penable = 1'b0;
        xfer(1'b0, 8'h20, 8'h00, 8'h42, 1'b0, "abt_rd20");
        idle("abt_rd20");

        // Reset in T2 of a write
        xfer(1'b1, 8'h02, 8'h5A, 8'h00, 1'b0, "rmt_pre");
        idle("rmt_pre");
        @(posedge pclk); #1;
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h99;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel2 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("rmt_pready",  pready2,  0);
        check("rmt_prdata",  prdata2,  8'h00);
        check("rmt_pslverr", pslverr2, 0);
        @(negedge pclk);
        check("rmt_pready_next", pready2, 0);
        xfer(1'b0, 8'h02, 8'h00, 8'h00, 1'b0, "rmt_rd02");
        idle("rmt_rd02");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
